register_file: RTL and testbench

- 32 x 32-bit general-purpose register file for the MIPS datapath, sitting between decode and writeback.
- Provides two combinational read ports (rs, rt) and one synchronous write port (rd) that is written every clock.
- Register 0 is hardwired to zero, following MIPS semantics.

---
 rtl/register_file.sv | 72 +++++++
 tb/tb_register_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports (rs, rt), one write port (rd) on every clock.
// Latency: reads are zero-cycle combinational; a write becomes visible after the rising edge that stores it.
// Backpressure: none; a write is taken every cycle, and the writeback stage steers rdIn to 0 when idle.
// Optional build macro: REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to a matching read port.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32  // must equal 2**ADDR_WIDTH so every address is in range
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] rsIn,
    input  logic [0:ADDR_WIDTH-1] rtIn,
    input  logic [0:ADDR_WIDTH-1] rdIn,
    output logic [0:DATA_WIDTH-1] rsOut,
    output logic [0:DATA_WIDTH-1] rtOut,
    input  logic [0:DATA_WIDTH-1] writeBackData
);

    // Storage keeps the MSB-first bit ordering of the ports so data passes through unchanged.
    logic [0:DATA_WIDTH-1] regs_q [NUM_REGS];
    logic [0:DATA_WIDTH-1] regs_d [NUM_REGS];

    logic rd_is_zero;
    assign rd_is_zero = (rdIn == '0);

    // Next-state: update the addressed register; register 0 is forced to zero so writes there are dropped.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (!rd_is_zero) begin
            regs_d[rdIn] = writeBackData;
        end
        regs_d[0] = '0;
    end

    // Array state: asynchronous clear on reset, otherwise capture the next-state every rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: address 0 and an active reset read zero; optional forwarding of the in-flight write.
    always_comb begin
        rsOut = regs_q[rsIn];
        rtOut = regs_q[rtIn];
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forwarding closes the writeback-to-decode hazard; address 0 is never forwarded.
        if (!rd_is_zero && (rsIn == rdIn)) begin
            rsOut = writeBackData;
        end
        if (!rd_is_zero && (rtIn == rdIn)) begin
            rtOut = writeBackData;
        end
`endif
        if (reset || (rsIn == '0)) begin
            rsOut = '0;
        end
        if (reset || (rtIn == '0)) begin
            rtOut = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a vector table of per-cycle writes/reads plus hand-written sequences
// for reset behaviour, same-cycle read/write, dual-port reads and reset in the middle of operation.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_register_file;

    logic        clock;
    logic        reset;
    logic [0:4]  rs_in;
    logic [0:4]  rt_in;
    logic [0:4]  rd_in;
    logic [0:31] rs_out;
    logic [0:31] rt_out;
    logic [0:31] wb_data;

    int total_checks;
    int passed_checks;

    register_file #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_REGS   (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rsIn          (rs_in),
        .rtIn          (rt_in),
        .rdIn          (rd_in),
        .rsOut         (rs_out),
        .rtOut         (rt_out),
        .writeBackData (wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs [9];

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clock);
        rd_in   = rd;
        wb_data = wd;
        rs_in   = rs;
        rt_in   = rt;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        reset   = 1'b1;
        rd_in   = 5'd0;
        rs_in   = 5'd0;
        rt_in   = 5'd0;
        wb_data = 32'h0;

        // Each row: drive rd/data/rs/rt, check reads before the edge, then the edge stores the write.
        // Reads of a register reflect writes from earlier rows only.
        vecs[0] = '{5'd2,  32'hDEED_DEED, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{5'd5,  32'hAAAA_DDDD, 5'd2,  5'd0,  32'hDEED_DEED, 32'h0000_0000};
        vecs[2] = '{5'd7,  32'hBEEF_DEED, 5'd5,  5'd2,  32'hAAAA_DDDD, 32'hDEED_DEED};
        vecs[3] = '{5'd0,  32'hFFFF_FFFF, 5'd7,  5'd0,  32'hBEEF_DEED, 32'h0000_0000};
        vecs[4] = '{5'd0,  32'h0000_0000, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{5'd3,  32'h1111_1111, 5'd7,  5'd5,  32'hBEEF_DEED, 32'hAAAA_DDDD};
        vecs[6] = '{5'd31, 32'h0123_4567, 5'd3,  5'd2,  32'h1111_1111, 32'hDEED_DEED};
        vecs[7] = '{5'd0,  32'h0000_0000, 5'd31, 5'd31, 32'h0123_4567, 32'h0123_4567};
        vecs[8] = '{5'd0,  32'h1234_5678, 5'd31, 5'd0,  32'h0123_4567, 32'h0000_0000};

        // Power-up reset: every read is zero while reset is held.
        for (int i = 0; i < 32; i++) begin
            rs_in = 5'(i);
            rt_in = 5'(31 - i);
            #1;
            check($sformatf("init_reset_rs[%0d]", i), rs_out, 32'h0);
            check($sformatf("init_reset_rt[%0d]", 31 - i), rt_out, 32'h0);
        end
        @(negedge clock);
        #2 reset = 1'b0;

        // Main table.
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].rd, vecs[v].wd, vecs[v].rs, vecs[v].rt);
            #1;
            check($sformatf("vec%0d_rs", v), rs_out, vecs[v].exp_rs);
            check($sformatf("vec%0d_rt", v), rt_out, vecs[v].exp_rt);
        end

        // Same-cycle read/write of R3 (holds 1111_1111).
        drive(5'd3, 32'h2222_2222, 5'd3, 5'd0);
        #1;
        check("same_cycle_pre_edge", rs_out, BYPASS ? 32'h2222_2222 : 32'h1111_1111);
        @(posedge clock);
        #1;
        check("same_cycle_post_edge", rs_out, 32'h2222_2222);

        // Dual-port same address, then an address change with no edge.
        drive(5'd0, 32'h0, 5'd31, 5'd31);
        #1;
        check("dual_rs31", rs_out, 32'h0123_4567);
        check("dual_rt31", rt_out, 32'h0123_4567);
        rs_in = 5'd0;
        #1;
        check("dual_rs_to0_comb", rs_out, 32'h0);
        check("dual_rt_hold", rt_out, 32'h0123_4567);

        // Mid-cycle reset clears outputs without an edge; sweep after release proves storage cleared.
        drive(5'd0, 32'h0, 5'd31, 5'd3);
        #1;
        check("pre_reset_r31", rs_out, 32'h0123_4567);
        #1 reset = 1'b1;
        #1;
        check("async_reset_rs", rs_out, 32'h0);
        check("async_reset_rt", rt_out, 32'h0);
        @(negedge clock);
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_in = 5'(i);
            rt_in = 5'(31 - i);
            #1;
            check($sformatf("post_reset_rs[%0d]", i), rs_out, 32'h0);
            check($sformatf("post_reset_rt[%0d]", 31 - i), rt_out, 32'h0);
        end

        // Reset mid-operation: R9 written, then reset held across an edge with a pending write to R9.
        drive(5'd9, 32'hCAFE_F00D, 5'd0, 5'd0);
        drive(5'd9, 32'h5555_5555, 5'd9, 5'd0);
        #1;
        check("r9_before_reset", rs_out, BYPASS ? 32'h5555_5555 : 32'hCAFE_F00D);
        #1 reset = 1'b1;
        #1;
        check("r9_in_reset", rs_out, 32'h0);
        @(posedge clock);
        #1;
        check("r9_reset_edge", rs_out, 32'h0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("r9_after_release", rs_out, BYPASS ? 32'h5555_5555 : 32'h0);
        @(posedge clock);
        #1;
        rd_in = 5'd0;
        #1;
        check("r9_first_post_reset_write", rs_out, 32'h5555_5555);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
